off_gesture_gen: RTL and testbench

Synthetic hand-trajectory generator for the "off" gesture. On a `start` pulse it drives left- and right-hand coordinate streams through the centre-out-out-back-centre sweep in the bottom third of the frame. It sits between the board controls and the gesture-recognition FSMs, standing in for the camera hand tracker. It gives bench and on-board self-test a deterministic gesture source that the off-detector must accept.

---
 rtl/off_gesture_gen.sv | 113 +++++++++++
 tb/tb_off_gesture_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/off_gesture_gen.sv
// off_gesture_gen: synthetic "off" gesture trajectory source (optional OFFGEN_LOOP_EN repeats gestures until abort)
module off_gesture_gen #(
    parameter int MAX_X = 1023,
    parameter int MAX_Y = 767,
    parameter int DWELL = 8
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [15:0] x1_o,
    output logic [15:0] y1_o,
    output logic [15:0] x2_o,
    output logic [15:0] y2_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  phase_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CENTER = 3'd1,
        OUT1   = 3'd2,
        OUT2   = 3'd3,
        BACK   = 3'd4,
        RETURN = 3'd5
    } state_t;

    localparam logic [15:0] Z0  = 16'((0 * MAX_X / 5 + 1 * MAX_X / 5) / 2);
    localparam logic [15:0] Z1  = 16'((1 * MAX_X / 5 + 2 * MAX_X / 5) / 2);
    localparam logic [15:0] Z2  = 16'((2 * MAX_X / 5 + 3 * MAX_X / 5) / 2);
    localparam logic [15:0] Z3  = 16'((3 * MAX_X / 5 + 4 * MAX_X / 5) / 2);
    localparam logic [15:0] Z4  = 16'((4 * MAX_X / 5 + 5 * MAX_X / 5) / 2);
    localparam logic [15:0] YB  = 16'((2 * MAX_Y / 3 + MAX_Y) / 2);
    localparam logic [15:0] YP  = 16'(MAX_Y / 4);
    localparam logic [15:0] DW1 = 16'(DWELL - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] x1_q, x1_d, x2_q, x2_d, y_q, y_d;
    logic        busy_q, busy_d, done_q, done_d;

    // Next state, dwell counter, and output coordinates decoded from the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                state_d = CENTER;
                cnt_d   = DW1;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = DW1;
            case (state_q)
                CENTER:  state_d = OUT1;
                OUT1:    state_d = OUT2;
                OUT2:    state_d = BACK;
                BACK:    state_d = RETURN;
                RETURN: begin
                    done_d = 1'b1;
`ifdef OFFGEN_LOOP_EN
                    state_d = CENTER;
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        x1_d   = (state_d == OUT2) ? Z0 : (state_d == OUT1 || state_d == BACK) ? Z1 : Z2;
        x2_d   = (state_d == OUT2) ? Z4 : (state_d == OUT1 || state_d == BACK) ? Z3 : Z2;
        y_d    = (state_d == IDLE) ? YP : YB;
        busy_d = (state_d != IDLE);
    end

    // State, counter and registered outputs; reset parks both hands immediately
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x1_q    <= Z2;
            x2_q    <= Z2;
            y_q     <= YP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x1_o    = x1_q;
    assign x2_o    = x2_q;
    assign y1_o    = y_q;
    assign y2_o    = y_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign phase_o = state_q;
endmodule

// File: tb/tb_off_gesture_gen.sv
// tb_off_gesture_gen: scoreboard bench for off_gesture_gen against a gesture-timeline reference model
module tb_off_gesture_gen;
    localparam int DW = 4;

    typedef struct packed {
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
        logic        busy;
        logic        done;
        logic [2:0]  ph;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] x1, y1, x2, y2;
    logic        busy, done;
    logic [2:0]  phase;

    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];

    // Model: a gesture is a timeline t = 0 .. 5*DW-1 of cycles since CENTER appeared
    bit   m_active = 1'b0;
    bit   m_done = 1'b0;
    int   m_t = 0;
    int   tx1[6] = '{7, 7, 4, 1, 4, 7};
    int   tx2[6] = '{7, 7, 10, 13, 10, 7};
    int   ty[6]  = '{3, 12, 12, 12, 12, 12};

    off_gesture_gen #(.MAX_X(15), .MAX_Y(15), .DWELL(DW)) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .start_i (start),
        .abort_i (abort),
        .x1_o    (x1),
        .y1_o    (y1),
        .x2_o    (x2),
        .y2_o    (y2),
        .busy_o  (busy),
        .done_o  (done),
        .phase_o (phase)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_out();
        obs_t o;
        int p;
        p = m_active ? (m_t / DW + 1) : 0;
        o.x1 = 16'(tx1[p]);
        o.x2 = 16'(tx2[p]);
        o.y1 = 16'(ty[p]);
        o.y2 = 16'(ty[p]);
        o.busy = m_active;
        o.done = m_done;
        o.ph = 3'(p);
        return o;
    endfunction

    // One cycle of stimulus; the expected post-edge outputs go into the scoreboard
    task automatic step(input logic r, input logic s, input logic a);
        @(negedge clk);
        #2;
        rst_n = r;
        start = s;
        abort = a;
        m_done = 1'b0;
        if (!r) begin
            m_active = 1'b0;
            m_t = 0;
        end else if (a) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t == 5 * DW) begin
                m_done = 1'b1;
`ifdef OFFGEN_LOOP_EN
                m_t = 0;
`else
                m_active = 1'b0;
`endif
            end
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle against the scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, g;
            e = exp_q.pop_front();
            g = '{x1, y1, x2, y2, busy, done, phase};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got x1=%0d y1=%0d x2=%0d y2=%0d busy=%0b done=%0b phase=%0d want x1=%0d y1=%0d x2=%0d y2=%0d busy=%0b done=%0b phase=%0d",
                         $time, g.x1, g.y1, g.x2, g.y2, g.busy, g.done, g.ph,
                         e.x1, e.y1, e.x2, e.y2, e.busy, e.done, e.ph);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b1, i == 0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, i == 0 || i == 6 || i == 10 || i == 21, 1'b0);
        for (int i = 0; i < 26; i++) step(1'b1, i == 0 || i == 21, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, i == 0, i == 10);
        for (int i = 0; i < 12; i++) step(i != 7, i == 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b1, i == 0, i == 45);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 299) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
